// File: rtl/amber128_ifetch_buffer.sv
// rtl/amber128_ifetch_buffer.sv - sequential bundle prefetch buffer with redirect flush for the amber128 IMEM port
module amber128_ifetch_buffer #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned BUNDLE_BYTES = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clk_en_i,
  input  logic [63:0]   core_addr_i,
  output logic [127:0]  core_data_o,
  output logic          core_valid_o,
  output logic          core_err_o,
  output logic          redirect_o,
  output logic          mem_req_o,
  output logic [63:0]   mem_addr_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [127:0]  mem_rdata_i,
  input  logic          mem_err_i
);

  localparam int unsigned OFF_W = $clog2(BUNDLE_BYTES);
  localparam int unsigned TAG_W = 64 - OFF_W;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // FIFO storage: one tag/data/error triple per entry
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [127:0]     data_q [DEPTH];
  logic [DEPTH-1:0] err_q;

  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [TAG_W-1:0] fetch_tag_q;
  logic [TAG_W-1:0] req_tag_q;
  logic             outstanding_q;
  logic             discard_q;
  logic             halt_q;

  logic [TAG_W-1:0] core_tag;
  logic [TAG_W-1:0] head_tag;
  logic [TAG_W-1:0] exp_tag;
  logic             not_empty;
  logic             mismatch;
  logic             resp;
  logic             pending_push;
  logic             pop;
  logic             grant;
  logic [CNT_W:0]   occupancy;
  logic             unused_addr_bits;

  assign core_tag         = core_addr_i[63:OFF_W];
  assign unused_addr_bits = ^core_addr_i[OFF_W-1:0];
  assign head_tag         = tag_q[rd_ptr_q];
  assign not_empty        = (count_q != '0);

  // Address the core is expected to ask for next; anything else (other than head+1) is a redirect
  always_comb begin
    exp_tag = fetch_tag_q;
    if (not_empty) begin
      exp_tag = head_tag;
    end else if (outstanding_q && !discard_q) begin
      exp_tag = req_tag_q;
    end
  end

  assign mismatch     = (core_tag != exp_tag) &&
                        !(not_empty && (core_tag == exp_tag + TAG_W'(1)));
  assign resp         = mem_rvalid_i && outstanding_q;
  assign pending_push = resp && !discard_q;
  assign pop          = not_empty && (core_tag == head_tag + TAG_W'(1));
  assign occupancy    = {1'b0, count_q} + {{CNT_W{1'b0}}, pending_push};

  assign mem_req_o    = !rst_i && !outstanding_q && !halt_q && !mismatch &&
                        (occupancy < (CNT_W+1)'(DEPTH));
  assign mem_addr_o   = {fetch_tag_q, {OFF_W{1'b0}}};
  assign grant        = mem_req_o && mem_gnt_i;

  assign redirect_o   = mismatch && clk_en_i && !rst_i;
  assign core_valid_o = not_empty && (head_tag == core_tag);
  assign core_err_o   = core_valid_o && err_q[rd_ptr_q];
  assign core_data_o  = data_q[rd_ptr_q];

  // Pointer, occupancy, request and flush state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      fetch_tag_q   <= '0;
      req_tag_q     <= '0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      halt_q        <= 1'b0;
    end else if (clk_en_i) begin
      if (mismatch) begin
        // Flush: a response landing now is consumed and dropped, a later one is squashed
        rd_ptr_q      <= '0;
        wr_ptr_q      <= '0;
        count_q       <= '0;
        fetch_tag_q   <= core_tag;
        halt_q        <= 1'b0;
        outstanding_q <= outstanding_q && !mem_rvalid_i;
        discard_q     <= outstanding_q && !mem_rvalid_i;
      end else begin
        if (grant) begin
          outstanding_q <= 1'b1;
          req_tag_q     <= fetch_tag_q;
          fetch_tag_q   <= fetch_tag_q + TAG_W'(1);
        end
        if (resp) begin
          outstanding_q <= 1'b0;
          discard_q     <= 1'b0;
          if (!discard_q && mem_err_i) begin
            halt_q <= 1'b1;
          end
        end
        if (pending_push) begin
          wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
        if (pending_push && !pop) begin
          count_q <= count_q + CNT_W'(1);
        end else if (pop && !pending_push) begin
          count_q <= count_q - CNT_W'(1);
        end
      end
    end
  end

  // Entry write on an accepted, non-squashed response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
      err_q <= '0;
    end else if (clk_en_i && !mismatch && pending_push) begin
      tag_q[wr_ptr_q]  <= req_tag_q;
      data_q[wr_ptr_q] <= mem_rdata_i;
      err_q[wr_ptr_q]  <= mem_err_i;
    end
  end

endmodule

// File: doc/amber128_ifetch_buffer.md
# amber128_ifetch_buffer

Bundle prefetch buffer between the instruction memory and the `amber128` core's IMEM port. It tracks the core's 128-bit bundle address (`imem_addr_o`) and prefetches sequential 16-byte bundles into a small tagged FIFO. It returns a bundle with `valid` when the head entry matches the requested address. Any non-sequential address change is treated as a redirect: the FIFO is flushed and an in-flight response is squashed.

## Interface
- `DEPTH`, 2: FIFO entries; power of two, ≥2.
- `BUNDLE_BYTES`, 16: address increment per bundle.

Ports (clock and reset first):
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `clk_en_i`  in  1  state advances only when 1. Outputs stay combinational from the held state.
- `core_addr_i`  in  64  bundle address from the core; bits [3:0] are ignored.
- `core_data_o`  out  128  head-entry bundle.
- `core_valid_o`  out  1  head entry matches `core_addr_i`.
- `core_err_o`  out  1  head entry carries a fetch error (qualified by `core_valid_o`).
- `redirect_o`  out  1  one-cycle pulse when a flush occurs.
- `mem_req_o`  out  1  fetch request.
- `mem_addr_o`  out  64  request address, with bits [3:0] = 0.
- `mem_gnt_i`  in  1  request accepted this cycle.
- `mem_rvalid_i`  in  1  response valid; one response per grant, in order.
- `mem_rdata_i`  in  128  response bundle.
- `mem_err_i`  in  1  response error, sampled with `mem_rvalid_i`.

## Operation
State:
- FIFO entries `{tag[63:4], data, err}`.
- `rd_ptr`, `wr_ptr`, `count` (0..DEPTH).
- `fetch_addr_q`: next address to request.
- `req_tag_q`: tag of the outstanding request.
- `outstanding_q`.
- `discard_q`.
- `halt_q`: set after an error entry is pushed.

Rules:
- **Expected address `exp`.**
  - If `count>0`: head tag.
  - Else if `outstanding_q && !discard_q`: `req_tag_q`.
  - Else: `fetch_addr_q[63:4]`.
- **Hit.** `core_valid_o = count>0 && head.tag == core_addr_i[63:4]`. `core_data_o` = head data (don't-care when not valid). `core_err_o = core_valid_o && head.err`.
- **Advance.** If `count>0` and `core_addr_i[63:4] == head.tag+1` (mod 2^60), pop the head. The new head is compared the following cycle.
- **Redirect.** Occurs when `core_addr_i[63:4]` equals neither `exp` nor (`count>0` and `exp+1`). On redirect:
  - `count`, `rd_ptr`, `wr_ptr` ← 0.
  - `fetch_addr_q` ← `{core_addr_i[63:4],4'b0}`.
  - `halt_q` ← 0.
  - `discard_q` ← `outstanding_q && !mem_rvalid_i`.
  - A response arriving in the same cycle is dropped.
  - `mem_req_o` is forced to 0 this cycle.
  - `redirect_o` = 1.
- **Request.**
  - `mem_req_o = !outstanding_q && !halt_q && !redirect && (count + pending_push) < DEPTH`.
  - `pending_push` = 1 if a non-discarded response is accepted this cycle.
  - `mem_addr_o = fetch_addr_q`.
  - On `mem_req_o && mem_gnt_i`: `outstanding_q` ← 1, `req_tag_q` ← `fetch_addr_q[63:4]`, `fetch_addr_q` += 16 (wraps mod 2^64).
  - Only one request is outstanding at a time. A new request is allowed in the cycle after `rvalid`.
- **Response.** On `mem_rvalid_i && outstanding_q`:
  - Clear `outstanding_q`.
  - If `discard_q`: clear it and drop the data.
  - Otherwise push `{req_tag_q, rdata, err}`. If `err`, set `halt_q`.
  - `mem_rvalid_i` without `outstanding_q` is ignored.
- **Simultaneous events.**
  - Pop and push in the same cycle leaves `count` unchanged.
  - A push while `count==DEPTH` cannot occur because of the request gating.
  - Redirect overrides pop, push and grant. A grant in the redirect cycle cannot occur because `mem_req_o` is 0.
- **Reset.** All state clears. `fetch_addr_q` = 0, so prefetch starts at address 0 on the first cycle after reset.

## Timing
- Reset values: `core_valid_o`=0, `core_err_o`=0, `redirect_o`=0, `mem_req_o`=0 during reset, `mem_addr_o`=0, `core_data_o`=0.
- With an empty FIFO, request granted in cycle t and `rvalid` in cycle t+k: `core_valid_o` = 1 at t+k+1 if the address matches.
- Back-to-back grants are possible every 2 cycles with `k`=1. `DEPTH` entries fill without core consumption, then `mem_req_o` stays 0.
- Redirect in cycle r: `mem_req_o` = 1 at r+1 with the new address. Earliest `core_valid_o` is r+3 with `k`=1.
- Sequential advance: pop at edge p; the next head is valid at p+1 if already buffered.
- `clk_en_i`=0 freezes all registers; handshake inputs that cycle are ignored.

## Test plan
- **Reset, then sequential fetch.** Reset, `core_addr_i`=0, memory `gnt`=1 with `k`=1 and `rdata`=addr-pattern. `mem_addr_o`=0x0 then 0x10. `core_valid_o` at cycle 3 with data for 0x0. Stepping the address to 0x10 gives valid the next cycle.
- **Full stall.** Hold `core_addr_i`=0 with `DEPTH`=2. After tags 0x0 and 0x10 are buffered, `mem_req_o` stays 0. Step to 0x10: 0x20 is requested.
- **Redirect with squash.** While a request for 0x20 is outstanding, set `core_addr_i`=0x400. `redirect_o` pulses; the late 0x20 response is dropped. `mem_addr_o`=0x400 next and `core_valid_o` only for 0x400 data.
- **Error.** `mem_err_i`=1 on 0x10. `core_err_o`=1 when `core_addr_i`=0x10, and no further requests. Redirecting to 0x0 resumes fetching.
- **Wrap-around.** Redirect to 0xFFFF_FFFF_FFFF_FFF0. The next request is 0x0, and stepping the address to 0x0 is an advance, not a redirect.
- **Simultaneous pop/push, and reset mid-request.** A response arriving in the same cycle as an advance keeps `count` correct. Asserting `rst_i` while outstanding clears all outputs, and a later stray `rvalid` is ignored.
